// File: rtl/multi_line_buffer.sv
// Line-delay buffer: NUM_LINES circular RAM rows give one vertically aligned column of NUM_LINES+1 taps per sample.
// Optional macro LINE_BUF_ZERO_PAD_EN zeroes taps whose rows have not yet been written since Reset.
module multi_line_buffer #(
  parameter  int DATA_W    = 8,
  parameter  int LINE_LEN  = 640,
  parameter  int NUM_LINES = 2,
  localparam int ADDR_W    = $clog2(LINE_LEN)
) (
  input  logic                          CLK,
  input  logic                          Reset,
  input  logic                          Enable,
  input  logic [DATA_W-1:0]             DataIn,
  output logic [(NUM_LINES+1)*DATA_W-1:0] DataOut,
  output logic                          Valid,
  output logic                          LineEnd,
  output logic [ADDR_W-1:0]             ColIdx
);

  localparam int CNT_W = $clog2(NUM_LINES + 1);

  localparam logic [0:0] S_FILL = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [DATA_W-1:0] r_mem [NUM_LINES][LINE_LEN];

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0]  r_line_cnt;
  logic [0:0]        r_state;

  logic [DATA_W-1:0]                  w_rd [NUM_LINES];
  logic [(NUM_LINES+1)*DATA_W-1:0]    w_next_dout;
  logic                               w_wrap;

  assign w_wrap = (r_wr_ptr == ADDR_W'(LINE_LEN - 1));

  always_comb begin
    for (int unsigned k = 0; k < NUM_LINES; k++) begin
      w_rd[k] = r_mem[k][r_wr_ptr];
    end
  end

  // Tap k (k>=1) is the value row k-1 held at this column before the cascade write.
  always_comb begin
    w_next_dout = '0;
    w_next_dout[DATA_W-1:0] = DataIn;
    for (int unsigned k = 1; k <= NUM_LINES; k++) begin
      w_next_dout[k*DATA_W +: DATA_W] = w_rd[k-1];
`ifdef LINE_BUF_ZERO_PAD_EN
      if (r_state == S_FILL && int'(r_line_cnt) < int'(k)) begin
        w_next_dout[k*DATA_W +: DATA_W] = '0;
      end
`endif
    end
  end

  // RAM is deliberately not reset; a sample arriving with Reset is dropped.
  always_ff @(posedge CLK) begin
    if (Enable && !Reset) begin
      r_mem[0][r_wr_ptr] <= DataIn;
      for (int unsigned k = 1; k < NUM_LINES; k++) begin
        r_mem[k][r_wr_ptr] <= w_rd[k-1];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      DataOut    <= '0;
      Valid      <= 1'b0;
      LineEnd    <= 1'b0;
      ColIdx     <= '0;
      r_wr_ptr   <= '0;
      r_line_cnt <= '0;
      r_state    <= S_FILL;
    end else if (Enable) begin
      DataOut  <= w_next_dout;
      ColIdx   <= r_wr_ptr;
      LineEnd  <= w_wrap;
      Valid    <= (r_state == S_RUN);
      r_wr_ptr <= w_wrap ? '0 : r_wr_ptr + 1'b1;
      if (r_state == S_FILL && w_wrap) begin
        r_line_cnt <= r_line_cnt + 1'b1;
        if (r_line_cnt == CNT_W'(NUM_LINES - 1)) begin
          r_state <= S_RUN;
        end
      end
    end else begin
      Valid   <= 1'b0;
      LineEnd <= 1'b0;
    end
  end

endmodule
